// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int DATA_W = 8;

    // Serial line levels
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
// Latency: tick_o is combinational from the counter flop (high in the last cycle of each bit).
// Backpressure: none; clear_i forces the count back to 0 on the next edge.
// Ports: clk_i/rst_i clock and async active-high reset, clear_i restart, tick_o last-cycle flag.
module baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);
    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CNT_LAST);

    // Wrapping on tick keeps the count inside 0..CLKS_PER_BIT-1, so no overflow.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from a FIFO read port and sends 8N1 (or 8E1) frames.
// Latency: read_en cycle -> first start-bit cycle is 2 clocks; back-to-back frames have 2 idle-high cycles between them.
// Backpressure: fetches only when tx_enable=1 and mem_empty=0; a frame in flight always completes.
// Ports: read_clk/reset clock and async active-high reset; mem_empty/fifo_out/read_en FIFO read side;
//        tx_enable fetch gate; tx serial line; busy not-idle flag; byte_done end-of-stop pulse.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic              read_clk,
    input  logic              reset,
    input  logic              mem_empty,
    input  logic [DATA_W-1:0] fifo_out,
    output logic              read_en,
    input  logic              tx_enable,
    output logic              tx,
    output logic              busy,
    output logic              byte_done
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              read_en_q;
    logic              byte_done_q, byte_done_d;
    logic              tick;
    logic              cnt_clear;
    logic              can_fetch;

    // Only consulted in IDLE and on the last STOP cycle, so mem_empty changes mid-frame are ignored.
    assign can_fetch = tx_enable && !mem_empty;

    // Restart the bit period on every state change; hold it at 0 outside the line-driving states.
    assign cnt_clear = (state_d != state_q) || (state_q inside {IDLE, FETCH, LOAD});

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk_i  (read_clk),
        .rst_i  (reset),
        .clear_i(cnt_clear),
        .tick_o (tick)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        parity_d    = parity_q;
        byte_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (can_fetch) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                // FIFO data is valid the cycle after the read strobe.
                shift_d  = fifo_out;
                parity_d = ^fifo_out;
                state_d  = START;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    byte_done_d = 1'b1;
                    state_d     = can_fetch ? FETCH : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level is computed for the state being entered so the tx flop lines up with state_q.
    always_comb begin
        tx_d = LINE_IDLE;
        case (state_d)
            START:   tx_d = LINE_START;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge read_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            parity_q    <= 1'b0;
            tx_q        <= LINE_IDLE;
            read_en_q   <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            parity_q    <= parity_d;
            tx_q        <= tx_d;
            read_en_q   <= (state_d == FETCH);
            byte_done_q <= byte_done_d;
        end
    end

    assign tx        = tx_q;
    assign read_en   = read_en_q;
    assign byte_done = byte_done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: two DUTs (no parity / even parity) fed from queue-based FIFO models.
// Latency: n/a.
// Backpressure: n/a.
module tb_fifo_uart_tx;
    localparam int CPB = 4;

    logic       read_clk = 1'b0;
    logic       reset    = 1'b1;
    logic [1:0] mem_empty = 2'b11;
    logic [1:0] tx_enable = 2'b00;
    logic [7:0] fifo_out0 = 8'h00;
    logic [7:0] fifo_out1 = 8'h00;
    logic [1:0] read_en, tx, busy, byte_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] fq0[$], fq1[$];    // FIFO contents
    logic [7:0] exp0[$], exp1[$];  // expected frame order
    logic [1:0] rd_prev = 2'b00;
    int rd_cnt[2]      = '{0, 0};
    int rd_cyc[2]      = '{-1, -1};
    int frames_done[2] = '{0, 0};
    int in_frame[2]    = '{0, 0};
    int start_cyc[2]   = '{-1, -1};
    int last_stop[2]   = '{-1, -1};
    int last_gap[2]    = '{-1, -1};
    int pushed[2]      = '{0, 0};

    always #5 read_clk = ~read_clk;
    always @(posedge read_clk) cyc <= cyc + 1;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
        .read_clk (read_clk),
        .reset    (reset),
        .mem_empty(mem_empty[0]),
        .fifo_out (fifo_out0),
        .read_en  (read_en[0]),
        .tx_enable(tx_enable[0]),
        .tx       (tx[0]),
        .busy     (busy[0]),
        .byte_done(byte_done[0])
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
        .read_clk (read_clk),
        .reset    (reset),
        .mem_empty(mem_empty[1]),
        .fifo_out (fifo_out1),
        .read_en  (read_en[1]),
        .tx_enable(tx_enable[1]),
        .tx       (tx[1]),
        .busy     (busy[1]),
        .byte_done(byte_done[1])
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // FIFO read model: data appears on fifo_out the cycle after read_en.
    always @(posedge read_clk) begin
        if (read_en[0]) begin
            rd_cnt[0]++;
            rd_cyc[0] = cyc;
            chk("read_en0_single_cycle", rd_prev[0], 0);
            chk("fifo0_underflow", fq0.size() == 0, 0);
            if (fq0.size() != 0) fifo_out0 <= fq0.pop_front();
        end
        if (read_en[1]) begin
            rd_cnt[1]++;
            rd_cyc[1] = cyc;
            chk("read_en1_single_cycle", rd_prev[1], 0);
            chk("fifo1_underflow", fq1.size() == 0, 0);
            if (fq1.size() != 0) fifo_out1 <= fq1.pop_front();
        end
        rd_prev <= read_en;
    end

    always @(negedge read_clk) begin
        mem_empty[0] = (fq0.size() == 0);
        mem_empty[1] = (fq1.size() == 0);
    end

    // Line receiver: decodes each frame from tx and compares it with the next expected byte.
    task automatic monitor(input int idx, input int nbits);
        logic [7:0] b;
        logic       exp_bits[11];
        bit         ok, aborted;
        forever begin
            @(negedge read_clk);
            if (reset) continue;
            if (tx[idx] !== 1'b0) begin
                chk($sformatf("byte_done%0d_outside_frame", idx), byte_done[idx], 0);
                continue;
            end
            in_frame[idx]  = 1;
            start_cyc[idx] = cyc;
            if (last_stop[idx] >= 0) last_gap[idx] = cyc - last_stop[idx] - 1;
            b = 8'h00;
            if (idx == 0) begin
                chk("unexpected_frame0", exp0.size() == 0, 0);
                if (exp0.size() != 0) b = exp0.pop_front();
            end else begin
                chk("unexpected_frame1", exp1.size() == 0, 0);
                if (exp1.size() != 0) b = exp1.pop_front();
            end
            exp_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) exp_bits[i + 1] = b[i];
            if (nbits == 11) exp_bits[9] = ^b;
            exp_bits[nbits - 1] = 1'b1;
            ok      = 1'b1;
            aborted = 1'b0;
            for (int k = 0; k < nbits * CPB; k++) begin
                if (k > 0) @(negedge read_clk);
                if (reset) begin
                    aborted = 1'b1;
                    break;
                end
                if (tx[idx] !== exp_bits[k / CPB] || busy[idx] !== 1'b1 || byte_done[idx] !== 1'b0) begin
                    if (ok) $display("FAIL frame%0d byte %02h bit-cycle %0d: tx=%b busy=%b byte_done=%b, expected tx=%b busy=1 byte_done=0",
                                     idx, b, k, tx[idx], busy[idx], byte_done[idx], exp_bits[k / CPB]);
                    ok = 1'b0;
                end
            end
            if (!aborted) begin
                last_stop[idx] = cyc;
                checks++;
                if (!ok) errors++;
                @(negedge read_clk);
                chk($sformatf("byte_done%0d_at_end_of_stop", idx), byte_done[idx], 1);
                frames_done[idx]++;
            end else begin
                last_stop[idx] = -1;
            end
            in_frame[idx] = 0;
        end
    endtask

    initial monitor(0, 10);
    initial monitor(1, 11);

    task automatic push(input int idx, input logic [7:0] b);
        pushed[idx]++;
        if (idx == 0) begin
            fq0.push_back(b);
            exp0.push_back(b);
        end else begin
            fq1.push_back(b);
            exp1.push_back(b);
        end
    endtask

    task automatic wait_idle(input int idx, input int limit);
        bit done = 1'b0;
        for (int t = 0; t < limit; t++) begin
            @(negedge read_clk);
            if (idx == 0) done = (fq0.size() == 0) && (exp0.size() == 0);
            else          done = (fq1.size() == 0) && (exp1.size() == 0);
            done = done && (busy[idx] == 1'b0) && (in_frame[idx] == 0);
            if (done) break;
        end
        chk($sformatf("drain%0d_within_budget", idx), done, 1);
        repeat (3) @(negedge read_clk);
    endtask

    task automatic wait_frame_start(input int idx, input int limit);
        bit seen = 1'b0;
        for (int t = 0; t < limit; t++) begin
            @(negedge read_clk);
            if (in_frame[idx] != 0) begin
                seen = 1'b1;
                break;
            end
        end
        chk($sformatf("frame%0d_started", idx), seen, 1);
    endtask

    task automatic idle_window(input string name, input int n);
        bit bad = 1'b0;
        int r0  = rd_cnt[0];
        for (int t = 0; t < n; t++) begin
            @(negedge read_clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || read_en[0] !== 1'b0) bad = 1'b1;
        end
        chk({name, "_line_idle"}, bad, 0);
        chk({name, "_no_reads"}, rd_cnt[0] - r0, 0);
    endtask

    initial begin
        int r0, f0, f1, target;
        bit hit;

        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1);
    end

    initial begin
        int r0, f0, target;
        bit hit;

        // Reset values
        repeat (3) @(negedge read_clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_tx%0d", i), tx[i], 1);
            chk($sformatf("reset_busy%0d", i), busy[i], 0);
            chk($sformatf("reset_read_en%0d", i), read_en[i], 0);
            chk($sformatf("reset_byte_done%0d", i), byte_done[i], 0);
        end
        reset = 1'b0;

        // Single byte
        r0 = rd_cnt[0]; f0 = frames_done[0];
        push(0, 8'hA5);
        tx_enable[0] = 1'b1;
        wait_idle(0, 200);
        chk("single_reads", rd_cnt[0] - r0, 1);
        chk("single_frames", frames_done[0] - f0, 1);
        chk("fetch_to_start_latency", start_cyc[0] - rd_cyc[0], 2);

        // Back-to-back
        r0 = rd_cnt[0]; f0 = frames_done[0];
        last_gap[0] = -1;
        push(0, 8'h00);
        push(0, 8'hFF);
        wait_idle(0, 300);
        chk("b2b_reads", rd_cnt[0] - r0, 2);
        chk("b2b_frames", frames_done[0] - f0, 2);
        chk("b2b_idle_gap", last_gap[0], 2);

        // Empty FIFO with transmit enabled, then data present with transmit held off
        idle_window("empty", 100);
        tx_enable[0] = 1'b0;
        push(0, 8'h3C);
        idle_window("holdoff", 100);
        tx_enable[0] = 1'b1;
        wait_idle(0, 200);

        // tx_enable dropped during DATA: frame finishes, second byte stays queued
        r0 = rd_cnt[0]; f0 = frames_done[0];
        push(0, 8'h5A);
        push(0, 8'hC3);
        wait_frame_start(0, 50);
        repeat (10) @(negedge read_clk);
        tx_enable[0] = 1'b0;
        repeat (80) @(negedge read_clk);
        chk("holdoff_frames", frames_done[0] - f0, 1);
        chk("holdoff_reads", rd_cnt[0] - r0, 1);
        chk("holdoff_busy", busy[0], 0);
        chk("holdoff_queue_left", fq0.size(), 1);
        tx_enable[0] = 1'b1;
        wait_idle(0, 200);

        // Reset during DATA bit 3 (byte 96: bit 3 is 0, so the line must jump to 1)
        push(0, 8'h96);
        wait_frame_start(0, 50);
        target = start_cyc[0] + CPB + 3 * CPB + 1;
        hit = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (cyc == target) begin
                hit = 1'b1;
                break;
            end
            @(negedge read_clk);
        end
        chk("reached_data_bit3", hit, 1);
        chk("pre_reset_tx", tx[0], 0);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_tx", tx[0], 1);
        chk("async_reset_busy", busy[0], 0);
        chk("async_reset_read_en", read_en[0], 0);
        repeat (2) @(negedge read_clk);
        reset = 1'b0;
        r0 = rd_cnt[0]; f0 = frames_done[0];
        push(0, 8'h4B);
        wait_idle(0, 200);
        chk("post_reset_reads", rd_cnt[0] - r0, 1);
        chk("post_reset_frames", frames_done[0] - f0, 1);

        // Even parity: 07 -> parity 1, 03 -> parity 0, 11-bit frames
        f0 = frames_done[1];
        push(1, 8'h07);
        push(1, 8'h03);
        tx_enable[1] = 1'b1;
        wait_idle(1, 300);
        chk("parity_frames", frames_done[1] - f0, 2);

        // Randomized traffic on both transmitters with random hold-off
        for (int n = 0; n < 30; n++) begin
            push($urandom_range(0, 1), 8'($urandom));
            tx_enable[0] = ($urandom_range(0, 3) != 0);
            tx_enable[1] = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 30)) @(negedge read_clk);
        end
        tx_enable = 2'b11;
        wait_idle(0, 3000);
        wait_idle(1, 3000);
        // one byte was lost to the mid-frame reset, so dut0 reads every pushed byte
        chk("total_reads0", rd_cnt[0], pushed[0]);
        chk("total_reads1", rd_cnt[1], pushed[1]);
        chk("total_frames0", frames_done[0], pushed[0] - 1);
        chk("total_frames1", frames_done[1], pushed[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: read_clk cycles per serial bit; legal range 2..1023.
REQ-002 SHALL have parameter PARITY_EN, default 0: 1 inserts an even-parity bit after the data bits.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; all flops on read_clk.
REQ-004 SHALL have port read_clk, input, 1 bit: the sole clock, i.e. the FIFO read-side clock.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port mem_empty, input, 1 bit: FIFO empty flag.
REQ-007 SHALL have port fifo_out, input, 8 bits: FIFO read data, valid the cycle after a granted read.
REQ-008 SHALL have port read_en, output, 1 bit: FIFO read strobe, one cycle per byte.
REQ-009 SHALL have port tx_enable, input, 1 bit: 0 holds off new byte fetches; a frame in flight always completes.
REQ-010 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port byte_done, output, 1 bit: one-cycle pulse at the end of each stop bit.

Function
REQ-013 SHALL use states IDLE, FETCH, LOAD, START, DATA, PARITY and STOP.
REQ-014 IDLE SHALL go to FETCH when tx_enable=1 and mem_empty=0; otherwise it SHALL stay in IDLE.
REQ-015 On entry to FETCH, read_en SHALL be driven high for exactly that one cycle, registered, with no combinational path from mem_empty.
REQ-016 FETCH SHALL go to LOAD unconditionally.
REQ-017 LOAD SHALL capture fifo_out into the shift register and compute parity as the XOR of the 8 bits.
REQ-018 LOAD SHALL go to START; the latency from the read_en cycle to the first START cycle is 2 clocks.
REQ-019 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-020 DATA SHALL send 8 bits LSB first, each held for CLKS_PER_BIT cycles.
REQ-021 The bit index SHALL be a 3-bit counter that wraps from 7 to 0 on exit from DATA.
REQ-022 After DATA the block SHALL go to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-023 PARITY SHALL drive tx to the even-parity bit for CLKS_PER_BIT cycles.
REQ-024 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then pulse byte_done.
REQ-025 After STOP the block SHALL go directly to FETCH if tx_enable=1 and mem_empty=0, giving back-to-back frames separated only by FETCH and LOAD (2 idle-high cycles); otherwise it SHALL go to IDLE.
REQ-026 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, reset to 0 on every state change, and never overflow.
REQ-027 tx SHALL be driven from a flop (glitch-free) and SHALL be 1 in IDLE, FETCH and LOAD.
REQ-028 mem_empty SHALL be sampled only in IDLE and in the last cycle of STOP; mem_empty rising during a frame SHALL have no effect.
REQ-029 tx_enable falling mid-frame SHALL let the current frame finish and then return to IDLE.

Reset
REQ-030 While reset=1, regardless of clock: state=IDLE, tx=1, read_en=0, busy=0, byte_done=0, and the shift register, bit index and baud counter SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately with tx=1 and SHALL NOT issue a retry; the byte is lost.
REQ-032 Reset deassertion SHALL be synchronised externally; the first fetch can occur no earlier than the 1st read_clk edge after release.

Structure
REQ-033 A shared package uart_pkg SHALL hold the state enum type, DATA_W=8, and the idle and start-bit line levels.
REQ-034 The single sub-module baud_tick (counter, CLKS_PER_BIT parameter, clear input, tick output) SHALL be instantiated once.
REQ-035 Everything else SHALL be flat in fifo_uart_tx.

Verification (CLKS_PER_BIT=4, PARITY_EN=0 unless stated)
REQ-036 Single byte: mem_empty=0 for one fetch, fifo_out=8'hA5 -> read_en 1 cycle; tx = 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles; byte_done pulses at cycle 40 after START entry; back to IDLE.
REQ-037 Back-to-back: bytes 8'h00 and 8'hFF queued -> exactly 2 read_en pulses; frames separated by exactly 2 tx-high cycles; 2 byte_done pulses.
REQ-038 Parity: PARITY_EN=1, byte 8'h07 -> parity bit 1; byte 8'h03 -> parity bit 0; frame length 11 bits = 44 cycles.
REQ-039 Empty and hold-off: mem_empty=1 or tx_enable=0 for 100 cycles -> read_en never asserts, tx=1, busy=0; tx_enable dropped during DATA -> frame completes, then IDLE even though mem_empty=0.
REQ-040 Reset mid-frame: reset=1 during DATA bit 3 -> tx=1, busy=0 and read_en=0 in the same cycle without a clock edge; after release, the next byte is fetched normally.
